// File: rtl/nibble_serial_loader_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_loader_if
//
// Serial bit stream handshake carried into nibble_serial_loader.
//
// Signals:
//   sin_valid - producer has a serial bit on sin_data this cycle
//   sin_data  - serial bit value
//   sin_ready - loader can take a bit this cycle
//
// Modports:
//   master - bit producer (drives valid/data, observes ready)
//   slave  - the loader (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface nibble_serial_loader_if;
    logic sin_valid;
    logic sin_data;
    logic sin_ready;

    modport master (
        output sin_valid,
        output sin_data,
        input  sin_ready
    );

    modport slave (
        input  sin_valid,
        input  sin_data,
        output sin_ready
    );
endinterface

// File: rtl/nibble_serial_loader.sv
// ---------------------------------------------------------------------------
// nibble_serial_loader
//
// Serial front end for the 4-bit parallel-load register. A frame is opened
// with start, then four data bits and one even-parity bit are taken over the
// sin valid/ready handshake. A good frame is committed to I with a one-cycle
// load pulse. A bad frame leaves I alone and gives a one-cycle err pulse.
//
// Parameters:
//   MSB_FIRST - 0: first data bit lands in I[0]; 1: first data bit in I[3]
//
// Ports:
//   clk   - clock, rising edge
//   rstb  - asynchronous active-low reset
//   start - frame start request, only looked at in IDLE
//   abort - synchronous cancel of the frame in progress
//   sin   - serial bit handshake (slave side)
//   I     - committed nibble, parallel input of the downstream register
//   load  - one-cycle commit pulse, load select of the downstream register
//   err   - one-cycle parity-error pulse
//   busy  - high in any state other than IDLE
// ---------------------------------------------------------------------------
module nibble_serial_loader #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          start,
    input  logic                          abort,
    nibble_serial_loader_if.slave         sin,
    output logic [3:0]                    I,
    output logic                          load,
    output logic                          err,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        LOAD   = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [3:0] sh;
    logic [1:0] bit_idx;
    logic       accept;

    // Handshake flags come straight from the state register so there is no
    // combinational path from any input to sin_ready or busy.
    assign sin.sin_ready = (state == DATA) || (state == PARITY);
    assign busy          = (state != IDLE);
    assign accept        = sin.sin_valid && sin.sin_ready;

    // In MSB-first mode the first bit has to land in sh[3]; 3 - cnt is the
    // bitwise inverse of the 2-bit counter.
    always_comb begin
        bit_idx = cnt;
        if (MSB_FIRST) begin
            bit_idx = ~cnt;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            cnt   <= 2'd0;
            sh    <= 4'd0;
            I     <= 4'd0;
            load  <= 1'b0;
            err   <= 1'b0;
        end else begin
            // load and err are pulses; they are only raised on the single
            // edge that leaves PARITY, so they can never overlap or repeat.
            load <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= DATA;
                        cnt   <= 2'd0;
                        sh    <= 4'd0;
                    end
                end
                DATA: begin
                    // abort takes priority over a bit arriving on the same edge
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= 2'd0;
                    end else if (accept) begin
                        sh[bit_idx] <= sin.sin_data;
                        cnt         <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (accept) begin
                        // Even parity: data bits plus parity bit must XOR to 0
                        if ((^sh ^ sin.sin_data) == 1'b0) begin
                            state <= LOAD;
                            I     <= sh;
                            load  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_loader.md
# nibble_serial_loader

Serial front end for the 4-bit parallel-load register. It receives a framed serial nibble over a valid/ready handshake and checks an even-parity bit. On success it presents the nibble on `I` and pulses `load` for one cycle, so the downstream register captures it on the following clock edge. On a parity failure the held nibble is left untouched and a one-cycle error pulse is raised.

## Interface
- `MSB_FIRST`, default 0: bit order. 0 means the first data bit lands in `I[0]`; 1 means the first data bit lands in `I[3]`.

- `clk`, input, 1: clock; all state updates on the rising edge.
- `rstb`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: frame start request; sampled only in IDLE.
- `abort`, input, 1: synchronous cancel of the frame in progress; returns to IDLE with no load and no err.
- `sin_valid`, input, 1: serial bit valid.
- `sin_data`, input, 1: serial bit value.
- `sin_ready`, output, 1: block accepts a bit this cycle; high only in DATA and PARITY.
- `I`, output, 4: committed nibble; drives the downstream register's parallel input.
- `load`, output, 1: one-cycle commit pulse; drives the downstream register's load select.
- `err`, output, 1: one-cycle parity-error pulse.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- Internal state: FSM state, 2-bit bit counter, 4-bit shift register `sh`, committed register `I`.
- A bit is accepted on an edge where `sin_valid && sin_ready`. With `sin_valid` low, state is held indefinitely and there is no timeout.
- FSM states and transitions:
  - IDLE: `sin_ready`=0. `start`=1 (and `abort`=0) → DATA; the same edge clears the counter and `sh`. Bits presented in IDLE are ignored.
  - DATA: each accepted bit is written to `sh[cnt]` (`MSB_FIRST`=0) or `sh[3-cnt]` (`MSB_FIRST`=1), then `cnt` increments. The accept with `cnt`==3 → PARITY, and `cnt` wraps to 0.
  - PARITY: on the accepted bit `p`, if `^sh ^ p` == 0 → LOAD and `I` <= `sh` on the same edge. Otherwise → IDLE with `err`=1 for the next cycle, and `I` is unchanged.
  - LOAD: `load`=1 for exactly this cycle → IDLE unconditionally. A `start` seen in LOAD is ignored.
- `abort`=1 in DATA or PARITY → IDLE on that edge. `sh` contents are discarded, `I` is unchanged, and `err`=0, even if a bit is accepted on the same edge.
- `abort` and `start` together in IDLE: `abort` wins and the block stays in IDLE.
- `start` in DATA, PARITY or LOAD has no effect and does not restart the frame.
- `I` changes only on the edge entering LOAD and holds between frames.
- `load` and `err` are registered, mutually exclusive and never asserted for two consecutive cycles.

## Timing
- Reset (`rstb`=0, asynchronous): state=IDLE, `cnt`=0, `sh`=0, `I`=4'b0000, `load`=0, `err`=0, `sin_ready`=0, `busy`=0. Release is synchronous to the next `clk` edge.
- Reset asserted mid-frame: immediate return to reset values, no `load` and no `err`.
- `sin_ready` and `busy` are decoded from registered state and contain no combinational path from inputs.
- Minimum frame: `start` accepted at edge E, data bits at E+1..E+4, parity at E+5. `load`=1 and the new `I` are valid in the cycle after E+5, and the downstream register captures at edge E+6. `busy` is high from after E through the LOAD cycle, which is 6 cycles.
- Earliest next `start` acceptance is the edge after the LOAD cycle, or the edge after the `err` cycle begins.
- A stalled `sin_valid` extends the frame one cycle per idle cycle.

## Test plan
- Reset with `MSB_FIRST`=0, `start` then bits 1,1,0,1 and parity 1 back-to-back → `I`=4'b1011, `load` high exactly one cycle, 6 cycles after `start` is sampled, `err`=0.
- Same frame with parity 0 → `err` pulses one cycle, `load` never asserts, `I` stays 4'b1011 from the prior frame (or 4'b0000 after reset).
- `MSB_FIRST`=1 with bits 1,0,0,0 and parity 1 → `I`=4'b1000. Insert 3 idle cycles of `sin_valid` low after the second bit → frame stretches by 3 cycles and the result is identical.
- `abort` asserted after 2 data bits with `sin_valid` high on the same edge → IDLE, `busy` low next cycle, no `load`/`err`, `I` unchanged. Then a new frame of 0,1,1,0 with parity 0 → `I`=4'b0110.
- `rstb` pulsed low during PARITY after a valid 4'b1111 → all outputs at reset values immediately, `I`=4'b0000, and no `load` after release.
- `start` and `abort` asserted together in IDLE → stays IDLE. `start` pulsed during DATA → ignored, and the frame completes with the original bits.
